// File: rtl/bt_uart_tx.sv
// bt_uart_tx: 8N1 UART transmitter toward the Bluetooth module.
// Bytes enter through a valid/ready handshake into a small FIFO and are
// serialized LSB-first on txd (start bit, 8 data bits, stop bit).
//
// Optional feature macro: BT_UART_TX_PARITY_EN
//   defined   -> an even-parity bit is inserted between data and stop (11-bit frame)
//   undefined -> plain 8N1, 10-bit frame
//
// Parameters:
//   BAUD_DIV   clk cycles per serial bit (2..65535)
//   FIFO_DEPTH byte buffer entries (power of two, 2..16)
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, taken when tx_valid && tx_ready
//   tx_valid  producer has a byte on tx_data
//   tx_ready  FIFO can accept a byte this cycle (from registered occupancy)
//   txd       serial line, idle high, driven from a flop
//   busy      frame on the line or FIFO non-empty (registered)
module bt_uart_tx #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned CNTW = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef BT_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
`ifdef BT_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;

  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            bit_tc;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign bit_tc     = (cnt_q == CNTW'(BAUD_DIV - 1));
  assign txd        = txd_q;
  assign busy       = busy_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (bit_tc) state_d = S_DATA;
      S_DATA: begin
        if (bit_tc && (idx_q == 3'd7)) begin
`ifdef BT_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef BT_UART_TX_PARITY_EN
      S_PARITY: if (bit_tc) state_d = S_STOP;
`endif
      // A queued byte goes straight into its start bit with no idle cycle.
      S_STOP:  if (bit_tc) state_d = fifo_empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and line outputs; txd_d follows the state being entered so the
  // flopped line matches the state on the same edge.
  always_comb begin
    pop     = 1'b0;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef BT_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE:  if (!fifo_empty) pop = 1'b1;
      S_START: if (bit_tc) idx_d = 3'd0;
      S_DATA: begin
        if (bit_tc) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP:  if (bit_tc && !fifo_empty) pop = 1'b1;
      default: ;
    endcase

    if (pop) begin
      shift_d = mem[rptr_q];
`ifdef BT_UART_TX_PARITY_EN
      par_d   = ^mem[rptr_q];
`endif
    end

    if ((state_d == S_IDLE) || (state_d != state_q) || bit_tc) cnt_d = '0;
    else                                                      cnt_d = cnt_q + CNTW'(1);

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef BT_UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase

    // Push term lets busy rise on the accepting edge itself.
    busy_d = (state_q != S_IDLE) || !fifo_empty || push;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef BT_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef BT_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // FIFO storage (no reset needed, validity is tracked by count_q)
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bt_uart_tx.sv
// Testbench for bt_uart_tx (BAUD_DIV=16, FIFO_DEPTH=4).
// Reference model: each accepted byte gets a frame start time computed
// arithmetically (one cycle after acceptance, or right after the previous
// frame), from which expected txd, tx_ready and busy are derived per cycle.
module tb_bt_uart_tx;

  localparam int B     = 16;
  localparam int DEPTH = 4;
`ifdef BT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  bt_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         cyc;
  int         n_total;
  int         n_pass;
  bit         chk_en;
  bit         m_ready;
  bit         m_busy;
  bit         last_acc;
  int         q_a[$];
  int         q_s[$];
  logic [7:0] q_d[$];
  int         last_s;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame10;  // LSB = start bit, then d0..d7, then stop
    logic       par;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    q_a.delete();
    q_s.delete();
    q_d.delete();
    last_s  = -100000;
    m_ready = 1'b1;
    m_busy  = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] d, input int t);
    int s;
    s = (t + 1 > last_s + FL) ? t + 1 : last_s + FL;
    q_a.push_back(t);
    q_s.push_back(s);
    q_d.push_back(d);
    last_s = s;
    while (q_a.size() > 1 && q_s[0] + FL < t - 1) begin
      void'(q_a.pop_front());
      void'(q_s.pop_front());
      void'(q_d.pop_front());
    end
  endtask

  task automatic model_eval(input int t, output logic etxd, output logic erdy, output logic ebusy);
    int occ;
    int k;
    logic [7:0] d;
    occ   = 0;
    etxd  = 1'b1;
    ebusy = 1'b0;
    foreach (q_a[i]) begin
      if (q_a[i] <= t && q_s[i] > t) occ++;
      if (q_a[i] <= t && t <= q_s[i] + FL) ebusy = 1'b1;
      if (q_s[i] <= t && t < q_s[i] + FL) begin
        k = (t - q_s[i]) / B;
        d = q_d[i];
        if (k == 0)                 etxd = 1'b0;
        else if (k <= 8)            etxd = d[k-1];
        else if (NB == 11 && k == 9) etxd = ^d;
        else                        etxd = 1'b1;
      end
    end
    erdy = (occ < DEPTH);
  endtask

  // One clock: model sees the handshake at the edge, outputs compared 1 time unit later.
  task automatic step();
    logic et, er, eb;
    @(posedge clk);
    cyc++;
    last_acc = rst_n && tx_valid && m_ready;
    if (last_acc) model_push(tx_data, cyc);
    #1;
    model_eval(cyc, et, er, eb);
    m_ready = er;
    m_busy  = eb;
    if (chk_en) begin
      check("txd", 32'(txd), 32'(et));
      check("tx_ready", 32'(tx_ready), 32'(er));
      check("busy", 32'(busy), 32'(eb));
    end
  endtask

  task automatic step_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic push_hold(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    last_acc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (last_acc) break;
    end
    check("push_timeout", 32'(last_acc), 32'd1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (!m_busy) break;
      step();
    end
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int lows;
    logic [10:0] fr;
    logic [7:0] bytes5[5];

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    chk_en   = 1'b0;
    cyc      = 0;
    n_total  = 0;
    n_pass   = 0;
    model_reset();

    vt[0] = '{8'h01, 10'b1000000010, 1'b1};
    vt[1] = '{8'h07, 10'b1000001110, 1'b1};
    vt[2] = '{8'h03, 10'b1000000110, 1'b0};
    vt[3] = '{8'hA5, 10'b1101001010, 1'b0};
    vt[4] = '{8'h0F, 10'b1000011110, 1'b0};
    vt[5] = '{8'h80, 10'b1100000000, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) step();

    // Table-driven single frames into an idle block
    for (int v = 0; v < 6; v++) begin
      wait_idle();
`ifdef BT_UART_TX_PARITY_EN
      fr = {1'b1, vt[v].par, vt[v].frame10[8:0]};
`else
      fr = {1'b0, vt[v].frame10};
`endif
      tx_valid = 1'b1;
      tx_data  = vt[v].data;
      step();
      tx_valid = 1'b0;
      check($sformatf("tbl_%02h_busy_on_accept", vt[v].data), 32'(busy), 32'd1);
      check($sformatf("tbl_%02h_txd_at_accept", vt[v].data), 32'(txd), 32'd1);
      s = cyc + 1;
      step();
      check($sformatf("tbl_%02h_start_latency", vt[v].data), 32'(txd), 32'd0);
      for (int i = 0; i < NB; i++) begin
        step_until(s + i * B + B / 2);
        check($sformatf("tbl_%02h_bit%0d", vt[v].data, i), 32'(txd), 32'(fr[i]));
      end
      step_until(s + FL);
      check($sformatf("tbl_%02h_busy_frame_end", vt[v].data), 32'(busy), 32'd1);
      step();
      check($sformatf("tbl_%02h_busy_drop", vt[v].data), 32'(busy), 32'd0);
    end

    // Burst of five consecutive pushes fills the FIFO; a sixth waits for a slot
    wait_idle();
    bytes5[0] = 8'hA5; bytes5[1] = 8'h3C; bytes5[2] = 8'hFF;
    bytes5[3] = 8'h00; bytes5[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      push_hold(bytes5[i]);
      tx_valid = 1'b1;
    end
    tx_valid = 1'b0;
    check("burst_full_ready", 32'(tx_ready), 32'd0);
    push_hold(8'h99);
    wait_idle();

    // Push and pop on the same edge at occupancy 2
    push_hold(8'h11);
    s = cyc + 1;
    push_hold(8'h22);
    push_hold(8'h33);
    step_until(s + FL - 1);
    tx_valid = 1'b1;
    tx_data  = 8'h44;
    step();
    tx_valid = 1'b0;
    check("pp_ready", 32'(tx_ready), 32'd1);
    check("pp_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset during data bit 4 of 0x0F, then a clean frame for 0x02
    push_hold(8'h0F);
    s = cyc + 1;
    step_until(s + 5 * B + 4);
    check("mid_bit4_txd", 32'(txd), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk_en = 1'b0;
    model_reset();
    step();
    step();
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    push_hold(8'h02);
    wait_idle();

    // Long idle: no spurious start bit
    lows = 0;
    repeat (300) begin
      step();
      if (txd == 1'b0) lows++;
    end
    check("idle_no_start", 32'(lows), 32'd0);
    check("idle_busy_end", 32'(busy), 32'd0);

    // Randomized traffic with alternating sparse and dense phases
    for (int i = 0; i < 2500; i++) begin
      if (!(tx_valid && !last_acc)) begin
        tx_valid = ($urandom_range(0, 99) < (((i / 500) % 2) ? 90 : 6));
        tx_data  = 8'($urandom);
      end
      step();
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
